seq_shifter: RTL and testbench

SEQ_SHIFTER -- requirements
Module: seq_shifter

---
 rtl/seq_shifter.sv | 126 ++++++++++++
 tb/tb_seq_shifter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: LSL/LSR/ASR/ROR by a captured amount, STEP bits per clock.
module seq_shifter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  localparam int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout,
  output logic             carry
);

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [AMT_W-1:0] rem;
  logic [1:0]       mode_q;
  logic             carry_int;

  logic [AMT_W-1:0] amt_sat_c;
  logic [31:0]      rem_ext_c;
  logic [31:0]      k_c;
  logic             last_c;
  logic [WIDTH-1:0] nxt_work_c;
  logic             nxt_carry_c;

  // Clamp out-of-range amounts only when the amount field can exceed WIDTH-1
  if ((1 << AMT_W) > WIDTH) begin : g_sat
    assign amt_sat_c = (amt > AMT_W'(WIDTH - 1)) ? AMT_W'(WIDTH - 1) : amt;
  end else begin : g_nosat
    assign amt_sat_c = amt;
  end

  // Bits to shift this cycle and whether this cycle finishes the operation
  always_comb begin
    rem_ext_c = 32'(rem);
    k_c       = (rem_ext_c < STEP) ? rem_ext_c : STEP;
    last_c    = (rem_ext_c <= STEP);
  end

  // Apply k single-bit steps; carry is the last bit to leave the register
  always_comb begin
    nxt_work_c  = work;
    nxt_carry_c = carry_int;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (i < k_c) begin
        case (mode_q)
          MODE_LSL: begin
            nxt_carry_c = nxt_work_c[WIDTH-1];
            nxt_work_c  = {nxt_work_c[WIDTH-2:0], 1'b0};
          end
          MODE_LSR: begin
            nxt_carry_c = nxt_work_c[0];
            nxt_work_c  = {1'b0, nxt_work_c[WIDTH-1:1]};
          end
          MODE_ASR: begin
            nxt_carry_c = nxt_work_c[0];
            nxt_work_c  = {nxt_work_c[WIDTH-1], nxt_work_c[WIDTH-1:1]};
          end
          default: begin
            nxt_carry_c = nxt_work_c[0];
            nxt_work_c  = {nxt_work_c[0], nxt_work_c[WIDTH-1:1]};
          end
        endcase
      end
    end
  end

  // Control FSM with registered status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sout      <= '0;
      carry     <= 1'b0;
      work      <= '0;
      rem       <= '0;
      mode_q    <= MODE_LSL;
      carry_int <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work      <= in;
            rem       <= amt_sat_c;
            mode_q    <= mode;
            carry_int <= 1'b0;
            state     <= SHIFT;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          work      <= nxt_work_c;
          rem       <= rem - AMT_W'(k_c);
          carry_int <= nxt_carry_c;
          if (last_c) begin
            sout  <= nxt_work_c;
            carry <= nxt_carry_c;
            done  <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=4) against an arithmetic model.
module tb_seq_shifter;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start [2];
  logic [W-1:0]  din   [2];
  logic [AW-1:0] amt   [2];
  logic [1:0]    mode  [2];
  logic          busy  [2];
  logic          done  [2];
  logic          carry [2];
  logic [W-1:0]  sout  [2];

  seq_shifter #(.WIDTH(16), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in(din[0]), .amt(amt[0]),
    .mode(mode[0]), .busy(busy[0]), .done(done[0]), .sout(sout[0]), .carry(carry[0])
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in(din[1]), .amt(amt[1]),
    .mode(mode[1]), .busy(busy[1]), .done(done[1]), .sout(sout[1]), .carry(carry[1])
  );

  int checks;
  int errors;

  function automatic int step_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int lat_of(int a, int st);
    int n;
    n = (a + st - 1) / st;
    return (n < 1) ? 1 : n;
  endfunction

  // Whole-operation result {carry, value} from plain shift arithmetic
  function automatic logic [W:0] ref_op(logic [W-1:0] x, int a, logic [1:0] md);
    logic [W-1:0] r;
    logic         c;
    case (md)
      2'b00:   r = x << a;
      2'b01:   r = x >> a;
      2'b10:   r = W'($signed(x) >>> a);
      default: r = (a == 0) ? x : ((x >> a) | (x << (W - a)));
    endcase
    if (a == 0)          c = 1'b0;
    else if (md == 2'b00) c = x[W-a];
    else                  c = x[a-1];
    return {c, r};
  endfunction

  // Transaction-level model: accept when idle, finish after the computed latency
  logic         m_busy  [2];
  logic         m_done  [2];
  logic         m_carry [2];
  logic [W-1:0] m_sout  [2];
  logic [W:0]   m_res   [2];
  int           m_cnt   [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_busy[i]  <= 1'b0;
        m_done[i]  <= 1'b0;
        m_carry[i] <= 1'b0;
        m_sout[i]  <= '0;
        m_res[i]   <= '0;
        m_cnt[i]   <= 0;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_cnt[i] <= 1) begin
            m_busy[i]  <= 1'b0;
            m_done[i]  <= 1'b1;
            m_sout[i]  <= m_res[i][W-1:0];
            m_carry[i] <= m_res[i][W];
          end else begin
            m_cnt[i] <= m_cnt[i] - 1;
          end
        end else if (start[i]) begin
          m_res[i]  <= ref_op(din[i], int'(amt[i]), mode[i]);
          m_cnt[i]  <= lat_of(int'(amt[i]), step_of(i));
          m_busy[i] <= 1'b1;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Caller is at a negedge; start is driven now so a done cycle can be reused
  task automatic op(int i, logic [W-1:0] x, logic [AW-1:0] a, logic [1:0] md,
                    logic [W-1:0] es, logic ec, int elat, bit poke_mid);
    int n;
    start[i] = 1'b1; din[i] = x; amt[i] = a; mode[i] = md;
    @(negedge clk);
    start[i] = 1'b0;
    din[i] = W'($urandom); amt[i] = AW'($urandom); mode[i] = 2'($urandom);
    n = 0;
    while (!done[i] && n < 100) begin
      start[i] = (poke_mid && n == 2);
      @(negedge clk);
      n++;
    end
    start[i] = 1'b0;
    chk("latency", 32'(n), 32'(elat));
    chk("sout", 32'(sout[i]), 32'(es));
    chk("carry", 32'(carry[i]), 32'(ec));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; din[i] = '0; amt[i] = '0; mode[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", 32'(busy[i]), 32'd0);
      chk("reset_done", 32'(done[i]), 32'd0);
      chk("reset_sout", 32'(sout[i]), 32'd0);
      chk("reset_carry", 32'(carry[i]), 32'd0);
    end

    // Cycle-by-cycle comparison against the model
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          checks++;
          if ({busy[i], done[i], carry[i], sout[i]} !==
              {m_busy[i], m_done[i], m_carry[i], m_sout[i]}) begin
            errors++;
            $display("FAIL cycle_cmp u%0d: busy/done/carry/sout got %b/%b/%b/%h expected %b/%b/%b/%h",
                     i, busy[i], done[i], carry[i], sout[i],
                     m_busy[i], m_done[i], m_carry[i], m_sout[i]);
          end
        end
      end
    join_none

    rst_n = 1'b1;
    @(negedge clk);

    op(0, 16'h0001, 4'd3, 2'b00, 16'h0008, 1'b0, 3, 1'b0);
    op(0, 16'h8004, 4'd2, 2'b10, 16'hE001, 1'b0, 2, 1'b0);
    op(0, 16'h0003, 4'd1, 2'b11, 16'h8001, 1'b1, 1, 1'b0);
    op(0, 16'h1234, 4'd0, 2'b01, 16'h1234, 1'b0, 1, 1'b0);
    op(1, 16'h00F1, 4'd5, 2'b00, 16'h1E20, 1'b0, 2, 1'b0);
    op(1, 16'h00A5, 4'd7, 2'b11, 16'h4A01, 1'b0, 2, 1'b0);
    // Mid-operation start ignored, then back-to-back from the done cycle
    op(0, 16'h01FF, 4'd8, 2'b00, 16'hFF00, 1'b1, 8, 1'b1);
    op(0, 16'h8000, 4'd15, 2'b01, 16'h0001, 1'b0, 15, 1'b0);
    op(1, 16'hF000, 4'd15, 2'b01, 16'h0001, 1'b1, 4, 1'b0);
    op(1, 16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 4, 1'b0);

    // Asynchronous reset in the middle of a shift aborts without done
    start[0] = 1'b1; din[0] = 16'h01FF; amt[0] = 4'd8; mode[0] = 2'b00;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy[0]), 32'd0);
    chk("async_sout", 32'(sout[0]), 32'd0);
    chk("async_carry", 32'(carry[0]), 32'd0);
    chk("async_sout_s4", 32'(sout[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done[0]), 32'd0);
    end
    op(0, 16'h0001, 4'd3, 2'b00, 16'h0008, 1'b0, 3, 1'b0);

    // Random traffic on both instances, including starts while busy
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < 2; i++) begin
        start[i] = ($urandom_range(0, 2) == 0);
        din[i]   = W'($urandom);
        amt[i]   = AW'($urandom);
        mode[i]  = 2'($urandom);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) start[i] = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
